// File: rtl/exec_unit_p.sv
// exec_unit_p: parametrised accumulator execute stage with a shift-add multiplier.
// Build option SAT_ARITH_EN: add/sub/inc/dec saturate instead of wrapping.
module exec_unit_p #(
    parameter int DW  = 16,
    parameter int SHW = $clog2(DW)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [1:0]    IDEN,
    input  logic [3:0]    OPCODE,
    input  logic [DW-1:0] OPERAND,
    output logic          READY,
    output logic          DONE,
    output logic [DW-1:0] RESULT,
    output logic [DW-1:0] RESULT_HI,
    output logic [DW-1:0] IN_ADDRESS_MEMORY,
    output logic [4:0]    FLAGS
);
`ifdef SAT_ARITH_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif
    localparam logic [DW:0]    ONE  = {{DW{1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT1 = {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_n;
    logic [DW-1:0] ar, hi, sr, mcand, p_hi, p_lo, lo_n, ar_n, sr_n;
    logic [DW:0] add, sub, inc, dec, step;
    logic [2:0] gel, gel_n;
    logic [SHW-1:0] cnt;
    logic carry, zero, carry_n, wr, accept, is_mul, last, big;

    assign accept = START && state == IDLE;
    assign is_mul = IDEN == 2'b01 && OPCODE == 4'h3;
    assign last   = &cnt;
    assign big    = |OPERAND[DW-1:SHW];
    assign add    = {1'b0, ar} + {1'b0, OPERAND};
    assign sub    = {1'b0, ar} - {1'b0, OPERAND};
    assign inc    = {1'b0, ar} + ONE;
    assign dec    = {1'b0, ar} - ONE;
    // One shift-add step: the carry out of the partial sum shifts into p_hi's MSB
    assign step   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
    assign lo_n   = {step[0], p_lo[DW-1:1]};

    assign READY             = state == IDLE;
    assign RESULT            = ar;
    assign RESULT_HI         = hi;
    assign IN_ADDRESS_MEMORY = sr;
    assign FLAGS             = {carry, zero, gel};

    always_comb begin
        state_n = state;
        ar_n    = ar;
        sr_n    = sr;
        carry_n = carry;
        gel_n   = gel;
        wr      = 1'b1;
        if (accept && is_mul) state_n = MUL;
        if (state == MUL && last) state_n = IDLE;
        if (IDEN != 2'b01) ar_n = OPERAND;
        else case (OPCODE)
            4'h0: ar_n = OPERAND;
            4'h1: begin ar_n = (SAT && add[DW]) ? '1 : add[DW-1:0]; carry_n = add[DW]; end
            4'h2: begin ar_n = (SAT && sub[DW]) ? '0 : sub[DW-1:0]; carry_n = sub[DW]; end
            4'h4: ar_n = big ? '0 : ar << OPERAND[SHW-1:0];
            4'h5: ar_n = big ? '0 : ar >> OPERAND[SHW-1:0];
            4'h6: begin ar_n = (SAT && inc[DW]) ? '1 : inc[DW-1:0]; carry_n = inc[DW]; end
            4'h7: begin ar_n = (SAT && dec[DW]) ? '0 : dec[DW-1:0]; carry_n = dec[DW]; end
            4'h8: begin wr = 1'b0; gel_n = {ar > OPERAND, ar == OPERAND, ar < OPERAND}; end
            4'hF: begin wr = 1'b0; sr_n = ar; end
            default: ar_n = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ar    <= '0;
            hi    <= '0;
            sr    <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            gel   <= '0;
            DONE  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
        end else begin
            state <= state_n;
            DONE  <= 1'b0;
            if (accept && is_mul) begin
                mcand <= ar;
                p_hi  <= '0;
                p_lo  <= OPERAND;
                cnt   <= '0;
            end else if (accept) begin
                DONE  <= 1'b1;
                sr    <= sr_n;
                carry <= carry_n;
                gel   <= gel_n;
                if (wr) begin
                    ar   <= ar_n;
                    zero <= ar_n == '0;
                end
            end
            if (state == MUL) begin
                p_hi <= step[DW:1];
                p_lo <= lo_n;
                cnt  <= cnt + CNT1;
                if (last) begin
                    ar   <= lo_n;
                    hi   <= step[DW:1];
                    zero <= lo_n == '0;
                    DONE <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_unit_p.sv
// tb_exec_unit_p: vector table plus scoreboard for exec_unit_p at DW=16,
// with hand-written multiply, held-START and mid-multiply reset sequences.
module tb_exec_unit_p;
    localparam int DW = 16;
`ifdef SAT_ARITH_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [1:0]    IDEN = 2'b00;
    logic [3:0]    OPCODE = 4'h0;
    logic [DW-1:0] OPERAND = '0;
    logic          READY, DONE;
    logic [DW-1:0] RESULT, RESULT_HI, IN_ADDRESS_MEMORY;
    logic [4:0]    FLAGS;

    exec_unit_p #(.DW(DW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .IDEN(IDEN), .OPCODE(OPCODE),
        .OPERAND(OPERAND), .READY(READY), .DONE(DONE), .RESULT(RESULT),
        .RESULT_HI(RESULT_HI), .IN_ADDRESS_MEMORY(IN_ADDRESS_MEMORY), .FLAGS(FLAGS)
    );

    always #5 CLK = ~CLK;

    typedef struct {logic [15:0] ar, hi, sr; logic [4:0] fl;} exp_t;
    typedef struct {logic [1:0] iden; logic [3:0] op; logic [15:0] opnd, ar, sr; logic [4:0] fl;} vec_t;

    exp_t sb[$];
    exp_t got;
    vec_t tbl[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] iden, input logic [3:0] op, input logic [15:0] opnd);
        START = 1'b1;
        IDEN = iden;
        OPCODE = op;
        OPERAND = opnd;
    endtask

    task automatic push(input logic [15:0] ar, input logic [15:0] hi, input logic [15:0] sr, input logic [4:0] fl);
        exp_t x;
        x.ar = ar;
        x.hi = hi;
        x.sr = sr;
        x.fl = fl;
        sb.push_back(x);
    endtask

    task automatic row(input logic [1:0] iden, input logic [3:0] op, input logic [15:0] opnd,
                       input logic [15:0] ar, input logic [15:0] sr, input logic [4:0] fl);
        vec_t v;
        v.iden = iden;
        v.op = op;
        v.opnd = opnd;
        v.ar = ar;
        v.sr = sr;
        v.fl = fl;
        tbl.push_back(v);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ar"}, RESULT, 0);
        chk({tag, "_hi"}, RESULT_HI, 0);
        chk({tag, "_sr"}, IN_ADDRESS_MEMORY, 0);
        chk({tag, "_flags"}, FLAGS, 0);
        chk({tag, "_ready"}, READY, 1);
        chk({tag, "_done"}, DONE, 0);
    endtask

    // Every DONE must retire exactly one queued expectation
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: DONE high with no pending operation");
            end else begin
                got = sb.pop_front();
                chk("sb_ar", RESULT, got.ar);
                chk("sb_hi", RESULT_HI, got.hi);
                chk("sb_sr", IN_ADDRESS_MEMORY, got.sr);
                chk("sb_flags", FLAGS, got.fl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // {iden, op, operand, AR, SR, {C,Z,G,E,L}} starting from reset state
        row(2'b00, 4'h0, 16'h00FF, 16'h00FF, 16'h0000, 5'b00000);
        row(2'b01, 4'h1, 16'hFF01, SAT ? 16'hFFFF : 16'h0000, 16'h0000, SAT ? 5'b10000 : 5'b11000);
        row(2'b01, 4'h0, 16'h1234, 16'h1234, 16'h0000, 5'b10000);
        row(2'b10, 4'h0, 16'h8001, 16'h8001, 16'h0000, 5'b10000);
        row(2'b01, 4'h4, 16'h0001, 16'h0002, 16'h0000, 5'b10000);
        row(2'b01, 4'h5, 16'h0014, 16'h0000, 16'h0000, 5'b11000);
        row(2'b01, 4'h0, 16'h0005, 16'h0005, 16'h0000, 5'b10000);
        row(2'b01, 4'h8, 16'h0005, 16'h0005, 16'h0000, 5'b10010);
        row(2'b01, 4'h8, 16'h0009, 16'h0005, 16'h0000, 5'b10001);
        row(2'b01, 4'h8, 16'h0003, 16'h0005, 16'h0000, 5'b10100);
        row(2'b01, 4'h0, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b10100);
        row(2'b01, 4'h6, 16'h0000, SAT ? 16'hFFFF : 16'h0000, 16'h0000, SAT ? 5'b10100 : 5'b11100);
        row(2'b01, 4'h0, 16'h0003, 16'h0003, 16'h0000, 5'b10100);
        row(2'b01, 4'h2, 16'h0005, SAT ? 16'h0000 : 16'hFFFE, 16'h0000, SAT ? 5'b11100 : 5'b10100);
        row(2'b01, 4'h0, 16'h0010, 16'h0010, 16'h0000, 5'b10100);
        row(2'b01, 4'h2, 16'h0004, 16'h000C, 16'h0000, 5'b00100);
        row(2'b01, 4'h7, 16'h0000, 16'h000B, 16'h0000, 5'b00100);
        row(2'b01, 4'h0, 16'h0000, 16'h0000, 16'h0000, 5'b01100);
        row(2'b01, 4'h7, 16'h0000, SAT ? 16'h0000 : 16'hFFFF, 16'h0000, SAT ? 5'b11100 : 5'b10100);
        row(2'b01, 4'h0, 16'hBEEF, 16'hBEEF, 16'h0000, 5'b10100);
        row(2'b01, 4'hF, 16'h1234, 16'hBEEF, 16'hBEEF, 5'b10100);
        row(2'b01, 4'hA, 16'h1234, 16'h0000, 16'hBEEF, 5'b11100);
        row(2'b10, 4'h0, 16'h0042, 16'h0042, 16'hBEEF, 5'b10100);
        row(2'b00, 4'h1, 16'h0007, 16'h0007, 16'hBEEF, 5'b10100);
        row(2'b01, 4'h1, 16'h0009, 16'h0010, 16'hBEEF, 5'b00100);
        row(2'b01, 4'h4, 16'h0010, 16'h0000, 16'hBEEF, 5'b01100);
        row(2'b01, 4'h0, 16'h00F0, 16'h00F0, 16'hBEEF, 5'b00100);
        row(2'b01, 4'h5, 16'h0004, 16'h000F, 16'hBEEF, 5'b00100);

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk_reset("reset");

        foreach (tbl[i]) begin
            drive(tbl[i].iden, tbl[i].op, tbl[i].opnd);
            push(tbl[i].ar, 16'h0000, tbl[i].sr, tbl[i].fl);
            @(posedge CLK);
            #1;
            chk("done_latency", DONE, 1);
        end
        START = 1'b0;
        @(posedge CLK);
        #1;
        chk("done_single_pulse", DONE, 0);

        // Multiply with START held high: the following load must wait for READY
        drive(2'b01, 4'h0, 16'h1234);
        push(16'h1234, 16'h0000, 16'hBEEF, 5'b00100);
        @(posedge CLK);
        #1;
        drive(2'b01, 4'h3, 16'h0100);
        push(16'h3400, 16'h0012, 16'hBEEF, 5'b00100);
        chk("ready_before_mul", READY, 1);
        @(posedge CLK);
        #1;
        drive(2'b01, 4'h0, 16'hFFFF);
        push(16'hFFFF, 16'h0012, 16'hBEEF, 5'b00100);
        for (int i = 1; i <= DW; i++) begin
            chk("mul_busy_ready_done", {READY, DONE}, 2'b00);
            chk("mul_ar_held", RESULT, 16'h1234);
            @(posedge CLK);
            #1;
        end
        chk("mul_done_ready", {READY, DONE}, 2'b11);
        @(posedge CLK);
        #1;
        chk("held_start_done", DONE, 1);
        drive(2'b01, 4'h3, 16'hFFFF);
        push(16'h0001, 16'hFFFE, 16'hBEEF, 5'b00100);
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge CLK);
            #1;
        end
        chk("sb_drain", sb.size(), 0);

        // Reset in the middle of a multiply: no DONE may follow
        drive(2'b01, 4'h3, 16'h0003);
        @(posedge CLK);
        #1;
        START = 1'b0;
        chk("abort_busy", READY, 0);
        repeat (5) begin
            @(posedge CLK);
            #1;
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk_reset("abort");
        repeat (25) begin
            @(posedge CLK);
            #1;
        end
        chk("abort_no_pending", sb.size(), 0);
        chk("abort_idle_ready", READY, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
